// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// pipelined_adder : WIDTH-bit add/subtract, carry chain cut into STAGES
//                   registered ripple segments with valid/ready flow control.
// Revision        : 1.0
// ============================================================================

module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   total_sum,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             w_stall;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && !w_stall;
  assign w_b_eff  = sub ? ~b : b;
  assign w_c0     = sub | carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // REM: operand bits still unconsumed on entry; LO: sum bits known on exit
    localparam int REM = WIDTH - k * CHUNK;
    localparam int LO  = (k + 1) * CHUNK;

    logic [REM-1:0]   w_a_in;
    logic [REM-1:0]   w_b_in;
    logic             w_cin;
    logic             w_vin;
    logic             w_a_msb;
    logic             w_b_msb;
    logic [CHUNK-1:0] w_psum;
    logic             w_cout;
    logic [LO-1:0]    w_sum_next;

    logic             r_valid;
    logic             r_carry;
    logic [LO-1:0]    r_sum;

    if (k == 0) begin : g_first
      assign w_a_in     = a;
      assign w_b_in     = w_b_eff;
      assign w_cin      = w_c0;
      assign w_vin      = w_accept;
      assign w_a_msb    = a[WIDTH-1];
      assign w_b_msb    = w_b_eff[WIDTH-1];
      assign w_sum_next = w_psum;
    end else begin : g_next
      assign w_a_in     = g_stage[k-1].g_hi.r_a_hi;
      assign w_b_in     = g_stage[k-1].g_hi.r_b_hi;
      assign w_cin      = g_stage[k-1].r_carry;
      assign w_vin      = g_stage[k-1].r_valid;
      assign w_a_msb    = g_stage[k-1].g_hi.r_a_msb;
      assign w_b_msb    = g_stage[k-1].g_hi.r_b_msb;
      assign w_sum_next = {w_psum, g_stage[k-1].r_sum};
    end

    always_comb begin : p_ripple
      logic c;
      w_psum = '0;
      c      = w_cin;
      for (int i = 0; i < CHUNK; i++) begin
        w_psum[i] = w_a_in[i] ^ w_b_in[i] ^ c;
        c         = (w_a_in[i] & w_b_in[i]) | (c & (w_a_in[i] ^ w_b_in[i]));
      end
      w_cout = c;
    end

    // Data registers load only on valid slots so idle outputs hold steady.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (!w_stall) begin
        r_valid <= w_vin;
        if (w_vin) begin
          r_carry <= w_cout;
          r_sum   <= w_sum_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_hi
      logic [REM-CHUNK-1:0] r_a_hi;
      logic [REM-CHUNK-1:0] r_b_hi;
      logic                 r_a_msb;
      logic                 r_b_msb;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_a_hi  <= '0;
          r_b_hi  <= '0;
          r_a_msb <= 1'b0;
          r_b_msb <= 1'b0;
        end else if (!w_stall && w_vin) begin
          r_a_hi  <= w_a_in[REM-1:CHUNK];
          r_b_hi  <= w_b_in[REM-1:CHUNK];
          r_a_msb <= w_a_msb;
          r_b_msb <= w_b_msb;
        end
      end
    end else begin : g_last
      // Overflow is resolved before the last register so the output is a pure flop.
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ovf <= 1'b0;
        end else if (!w_stall && w_vin) begin
          r_ovf <= (w_a_msb == w_b_msb) && (w_psum[CHUNK-1] != w_a_msb);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign total_sum = {g_stage[STAGES-1].r_carry, g_stage[STAGES-1].r_sum};
  assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule

`default_nettype wire
